// File: rtl/muldiv_seq_ctrl.sv
// muldiv_seq_ctrl: multi-cycle sequencer that borrows the shared 8-bit
// adder/subtractor to perform unsigned 8x8 multiply (shift-add) and unsigned
// 8/8 divide (restoring). It takes eight RUN cycles per operation.
//
// Handshake: a request is accepted when start is high on a rising edge while
// the sequencer is idle. op/a/b are sampled on that edge only. busy is high
// during the eight RUN cycles. done pulses for exactly one cycle when hi/lo
// (and div_by_zero) are valid. There is no backpressure, and a start that
// arrives while busy or done is dropped.
module muldiv_seq_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] as_a,
    output logic [WIDTH-1:0] as_b,
    output logic             as_sel,
    input  logic [WIDTH-1:0] as_result,
    input  logic             as_cout
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [2:0] LAST_STEP = 3'd7;

    logic [1:0]       state_q, state_d;
    logic [2:0]       count_q, count_d;
    logic             op_q, op_d;
    logic [WIDTH-1:0] m_q, m_d;        // multiplier M or divisor D
    logic [WIDTH-1:0] p_hi_q, p_hi_d;
    logic [WIDTH-1:0] p_lo_q, p_lo_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] div_t_lo;        // low bits of the shifted partial remainder
    logic             div_q_bit;
    logic [WIDTH-1:0] step_hi;
    logic [WIDTH-1:0] step_lo;

    // The shifted partial remainder {P_hi, P_lo[7]}. Its top bit is P_hi[7].
    assign div_t_lo  = {p_hi_q[WIDTH-2:0], p_lo_q[WIDTH-1]};
    // A quotient bit is 1 when the 9-bit remainder is at least D. Either its top
    // bit is set, or the subtract of its low 8 bits did not borrow.
    assign div_q_bit = p_hi_q[WIDTH-1] | ~as_cout;

    // Drive the shared AddSub. It is used only in RUN and is held at zero otherwise.
    always_comb begin
        as_a   = '0;
        as_b   = '0;
        as_sel = 1'b0;
        if (state_q == ST_RUN) begin
            as_b = m_q;
            if (op_q) begin
                as_a   = div_t_lo;
                as_sel = 1'b1;
            end else begin
                as_a   = p_hi_q;
                as_sel = 1'b0;
            end
        end
    end

    // One iteration of shift-add or restoring divide, computed from the AddSub output.
    always_comb begin
        step_hi = p_hi_q;
        step_lo = p_lo_q;
        if (op_q) begin
            step_hi = div_q_bit ? as_result : div_t_lo;
            step_lo = {p_lo_q[WIDTH-2:0], div_q_bit};
        end else if (p_lo_q[0]) begin
            step_hi = {as_cout, as_result[WIDTH-1:1]};
            step_lo = {as_result[0], p_lo_q[WIDTH-1:1]};
        end else begin
            step_hi = {1'b0, p_hi_q[WIDTH-1:1]};
            step_lo = {p_hi_q[0], p_lo_q[WIDTH-1:1]};
        end
    end

    // Next-state logic for the FSM, the working registers and the result registers.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        op_d    = op_q;
        m_d     = m_q;
        p_hi_d  = p_hi_q;
        p_lo_d  = p_lo_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    if (op && (b == '0)) begin
                        // Divide by zero finishes at once with a fixed result.
                        state_d = ST_DONE;
                        hi_d    = a;
                        lo_d    = '1;
                        done_d  = 1'b1;
                        dbz_d   = 1'b1;
                    end else begin
                        state_d = ST_RUN;
                        op_d    = op;
                        m_d     = b;
                        p_hi_d  = '0;
                        p_lo_d  = a;
                        count_d = '0;
                    end
                end
            end
            ST_RUN: begin
                p_hi_d  = step_hi;
                p_lo_d  = step_lo;
                count_d = count_q + 3'd1;   // wraps to 0 on the final step
                if (count_q == LAST_STEP) begin
                    state_d = ST_DONE;
                    hi_d    = step_hi;
                    lo_d    = step_lo;
                    done_d  = 1'b1;
                    dbz_d   = 1'b0;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset returns to idle and drops any partial result.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            op_q    <= 1'b0;
            m_q     <= '0;
            p_hi_q  <= '0;
            p_lo_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            op_q    <= op_d;
            m_q     <= m_d;
            p_hi_q  <= p_hi_d;
            p_lo_q  <= p_lo_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign busy        = (state_q == ST_RUN);
    assign done        = done_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_seq_ctrl.sv
// tb_muldiv_seq_ctrl: directed test of the multiply/divide sequencer with a
// behavioural adder/subtractor attached to its AddSub ports.
module tb_muldiv_seq_ctrl;

    logic       clk;
    logic       reset;
    logic       start;
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic       busy;
    logic       done;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       div_by_zero;
    logic [7:0] as_a;
    logic [7:0] as_b;
    logic       as_sel;
    logic [7:0] as_result;
    logic       as_cout;

    int checks = 0;
    int errors = 0;

    // Per-operation observations filled in by do_op.
    int         busy_n;
    int         done_cyc;
    logic [7:0] r_hi;
    logic [7:0] r_lo;
    logic       r_dbz;
    logic [7:0] c1_as_a;
    logic [7:0] c1_as_b;
    logic       c1_as_sel;
    int         done_seen;

    muldiv_seq_ctrl #(.WIDTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .hi          (hi),
        .lo          (lo),
        .div_by_zero (div_by_zero),
        .as_a        (as_a),
        .as_b        (as_b),
        .as_sel      (as_sel),
        .as_result   (as_result),
        .as_cout     (as_cout)
    );

    // Clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural AddSub: carry-out on add, borrow (A<B) on subtract.
    always_comb begin
        logic [8:0] s;
        s = 9'd0;
        if (as_sel) begin
            s = {1'b0, as_a} - {1'b0, as_b};
            as_result = s[7:0];
            as_cout   = (as_a < as_b);
        end else begin
            s = {1'b0, as_a} + {1'b0, as_b};
            as_result = s[7:0];
            as_cout   = s[8];
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one operation from IDLE and follow it until done, or until 20 cycles pass.
    // When noise is set, a conflicting divide-by-zero start is pulsed during RUN.
    task automatic do_op(input logic op_v, input logic [7:0] a_v, input logic [7:0] b_v,
                         input logic noise);
        int cyc;
        busy_n    = 0;
        done_cyc  = -1;
        r_hi      = 8'hxx;
        r_lo      = 8'hxx;
        r_dbz     = 1'bx;
        c1_as_a   = 8'hxx;
        c1_as_b   = 8'hxx;
        c1_as_sel = 1'bx;
        start = 1'b1;
        op    = op_v;
        a     = a_v;
        b     = b_v;
        @(posedge clk); #1;   // edge E0
        start = 1'b0;
        op    = $urandom_range(0, 1);
        a     = 8'($urandom_range(0, 255));
        b     = 8'($urandom_range(0, 255));
        cyc   = 1;
        while (cyc <= 20) begin
            @(negedge clk);
            if (cyc == 1) begin
                c1_as_a   = as_a;
                c1_as_b   = as_b;
                c1_as_sel = as_sel;
            end
            if (busy) busy_n++;
            if (done) begin
                done_cyc = cyc;
                r_hi     = hi;
                r_lo     = lo;
                r_dbz    = div_by_zero;
                break;
            end
            @(posedge clk); #1;
            cyc++;
            if (noise && cyc == 3) begin
                start = 1'b1;
                op    = 1'b1;
                a     = 8'h77;
                b     = 8'h00;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        @(posedge clk); #1;   // leave DONE; now idle
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        op    = 1'b0;
        a     = 8'h00;
        b     = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);

        // Reset state.
        chk("rst_busy",  {15'd0, busy},        16'd0);
        chk("rst_done",  {15'd0, done},        16'd0);
        chk("rst_hi",    {8'd0, hi},           16'd0);
        chk("rst_lo",    {8'd0, lo},           16'd0);
        chk("rst_dbz",   {15'd0, div_by_zero}, 16'd0);
        chk("rst_as_a",  {8'd0, as_a},         16'd0);
        chk("rst_as_b",  {8'd0, as_b},         16'd0);
        chk("rst_as_sel",{15'd0, as_sel},      16'd0);
        @(posedge clk); #1;

        // 13 * 11 = 143
        do_op(1'b0, 8'd13, 8'd11, 1'b0);
        chk("m13x11_done_cyc", 16'(done_cyc), 16'd9);
        chk("m13x11_busy_n",   16'(busy_n),   16'd8);
        chk("m13x11_hilo",     {r_hi, r_lo},  16'h008F);
        chk("m13x11_dbz",      {15'd0, r_dbz}, 16'd0);
        chk("m13x11_c1_as",    {c1_as_a, c1_as_b}, 16'h000B);
        chk("m13x11_c1_sel",   {15'd0, c1_as_sel}, 16'd0);
        chk("m13x11_done_pulse", {15'd0, done}, 16'd0);
        chk("m13x11_hold",     {hi, lo},      16'h008F);

        // 255 * 255 = 0xFE01 (exercises carry-out into P_hi)
        do_op(1'b0, 8'hFF, 8'hFF, 1'b0);
        chk("m255x255_done_cyc", 16'(done_cyc), 16'd9);
        chk("m255x255_hilo",     {r_hi, r_lo},  16'hFE01);

        // 200 / 7 = 28 rem 4
        do_op(1'b1, 8'd200, 8'd7, 1'b0);
        chk("d200_7_done_cyc", 16'(done_cyc), 16'd9);
        chk("d200_7_busy_n",   16'(busy_n),   16'd8);
        chk("d200_7_hilo",     {r_hi, r_lo},  16'h041C);
        chk("d200_7_dbz",      {15'd0, r_dbz}, 16'd0);
        chk("d200_7_c1_as",    {c1_as_a, c1_as_b}, 16'h0107);
        chk("d200_7_c1_sel",   {15'd0, c1_as_sel}, 16'd1);

        // 0xFF / 0x81 = 1 rem 0x7E
        do_op(1'b1, 8'hFF, 8'h81, 1'b0);
        chk("dFF_81_hilo", {r_hi, r_lo}, 16'h7E01);

        // 0x05 / 0x09 = 0 rem 5
        do_op(1'b1, 8'h05, 8'h09, 1'b0);
        chk("d05_09_hilo", {r_hi, r_lo}, 16'h0500);

        // 0x5A / 0: immediate done with fixed result
        do_op(1'b1, 8'h5A, 8'h00, 1'b0);
        chk("dz_done_cyc", 16'(done_cyc), 16'd1);
        chk("dz_busy_n",   16'(busy_n),   16'd0);
        chk("dz_hilo",     {r_hi, r_lo},  16'h5AFF);
        chk("dz_dbz",      {15'd0, r_dbz}, 16'd1);
        chk("dz_hold_dbz", {15'd0, div_by_zero}, 16'd1);

        // Reset during the fifth RUN cycle (count = 4).
        start = 1'b1;
        op    = 1'b0;
        a     = 8'd200;
        b     = 8'd200;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("mid_rst_busy",  {15'd0, busy},        16'd0);
        chk("mid_rst_done",  {15'd0, done},        16'd0);
        chk("mid_rst_hilo",  {hi, lo},             16'h0000);
        chk("mid_rst_dbz",   {15'd0, div_by_zero}, 16'd0);
        chk("mid_rst_as",    {as_a, as_b},         16'h0000);
        @(posedge clk); #1;
        reset = 1'b0;
        done_seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) done_seen++;
        end
        chk("mid_rst_no_done", 16'(done_seen), 16'd0);
        @(posedge clk); #1;

        // 3 * 4 = 12 after the reset, with a stray start pulsed during RUN.
        do_op(1'b0, 8'd3, 8'd4, 1'b1);
        chk("m3x4_done_cyc", 16'(done_cyc), 16'd9);
        chk("m3x4_busy_n",   16'(busy_n),   16'd8);
        chk("m3x4_hilo",     {r_hi, r_lo},  16'h000C);
        chk("m3x4_dbz",      {15'd0, r_dbz}, 16'd0);

        // Back-to-back issue from the idle cycle after done.
        do_op(1'b0, 8'd16, 8'd16, 1'b0);
        chk("b2b_done_cyc", 16'(done_cyc), 16'd9);
        chk("b2b_hilo",     {r_hi, r_lo},  16'h0100);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
